anu_fifo_rd: RTL and testbench

Single-clock synchronous FIFO built around its read end. Words are pushed by a simple write strobe and drained through a first-word-fall-through valid/ready stream. It sits between the pin-level input capture (`ui_in` side) and the output pins (`uo_out` side) of the `tt_um_anu_fifo_cd` top. It provides occupancy and full status, plus an optional sticky overflow flag.

---
 rtl/anu_fifo_pkg.sv | 11 +
 rtl/anu_fifo_mem.sv | 23 ++
 rtl/anu_fifo_rd.sv | 90 +++++++++
 tb/tb_anu_fifo_rd.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/anu_fifo_pkg.sv
// Shared defaults and types for the anu_fifo read-side FIFO slice.
package anu_fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;
  // Address bits into the array; pointers carry one extra wrap bit on top.
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/anu_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port, no reset.
module anu_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/anu_fifo_rd.sv
// Single-clock FWFT FIFO: write strobe in, valid/ready stream out, level/full status.
// Optional sticky overflow flag enabled by defining ANU_FIFO_OVF_FLAG_EN.
module anu_fifo_rd
  import anu_fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [PTR_W:0]   level,
  input  logic             clr_ovf,
  output logic             ovf
);

  // Stream handshake: a word moves when rd_valid and rd_ready are both high at
  // a rising edge; rd_valid depends only on stored state, never on rd_ready.

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           push, pop;

  // Equal low bits with differing wrap bits means the writer is a full lap ahead.
  assign full     = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                    (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign rd_valid = (wr_ptr_q != rd_ptr_q);
  assign level    = wr_ptr_q - rd_ptr_q;

  assign push = wr_en & ~full;
  assign pop  = rd_valid & rd_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  anu_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (push),
    .waddr_i(wr_ptr_q[PTR_W-1:0]),
    .wdata_i(wr_data),
    .raddr_i(rd_ptr_q[PTR_W-1:0]),
    .rdata_o(rd_data)
  );

`ifdef ANU_FIFO_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  // A refused push sets the flag; setting takes priority over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf)        ovf_d = 1'b0;
    if (wr_en && full)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_clr_ovf;
  assign unused_clr_ovf = clr_ovf;
  assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_anu_fifo_rd.sv
// Self-checking bench for anu_fifo_rd: scenario tasks plus a FIFO-order scoreboard.
module tb_anu_fifo_rd;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          full;
  logic          rd_valid;
  logic          rd_ready;
  logic [W-1:0]  rd_data;
  logic [LW-1:0] level;
  logic          clr_ovf;
  logic          ovf;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_ovf = 1'b0;

  anu_fifo_rd #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data (rd_data),
    .level   (level),
    .clr_ovf (clr_ovf),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // One clock of stimulus. Before the edge, rd_valid and any popped word are
  // checked against the model; after the edge, ovf is checked.
  task automatic drive_cycle(input logic wr, input logic [W-1:0] d,
                             input logic rdy, input logic clr);
    int  lvl0;
    logic [W-1:0] exp_word;
    wr_en = wr; wr_data = d; rd_ready = rdy; clr_ovf = clr;
    #1;
    lvl0 = exp_q.size();
    n_cmp++;
    if (rd_valid !== (lvl0 > 0)) begin
      n_err++;
      $display("FAIL rd_valid_pre: got %b want %b", rd_valid, (lvl0 > 0));
    end
    if (rdy && lvl0 > 0) begin
      exp_word = exp_q.pop_front();
      n_cmp++;
      if (rd_data !== exp_word) begin
        n_err++;
        $display("FAIL pop_data: got %02h want %02h", rd_data, exp_word);
      end
    end
    if (wr && lvl0 < DEPTH) exp_q.push_back(d);
`ifdef ANU_FIFO_OVF_FLAG_EN
    if (wr && lvl0 == DEPTH) exp_ovf = 1'b1;
    else if (clr)            exp_ovf = 1'b0;
`endif
    @(posedge clk); #1;
    wr_en = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
    n_cmp++;
    if (ovf !== exp_ovf) begin
      n_err++;
      $display("FAIL ovf: got %b want %b", ovf, exp_ovf);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_ready = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n_cmp++;
    if (level !== '0 || rd_valid !== 1'b0 || full !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: lvl=%0d v=%b f=%b o=%b want 0/0/0/0", level, rd_valid, full, ovf);
    end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      n_cmp++;
      if (level !== '0 || rd_valid !== 1'b0) begin
        n_err++;
        $display("FAIL idle_ready: lvl=%0d v=%b want 0/0", level, rd_valid);
      end
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, vals[i], 1'b0, 1'b0);
      n_cmp++;
      if (level !== LW'(i + 1) || rd_data !== 8'h11) begin
        n_err++;
        $display("FAIL basic_fill: lvl=%0d data=%02h want %0d/11", level, rd_data, i + 1);
      end
    end
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
    n_cmp++;
    if (rd_valid !== 1'b0 || level !== '0) begin
      n_err++;
      $display("FAIL basic_empty: v=%b lvl=%0d want 0/0", rd_valid, level);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, W'(i), 1'b0, 1'b0);
    n_cmp++;
    if (full !== 1'b1 || level !== LW'(DEPTH)) begin
      n_err++;
      $display("FAIL fill_full: f=%b lvl=%0d want 1/%0d", full, level, DEPTH);
    end
    drive_cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    n_cmp++;
    if (level !== LW'(DEPTH) || rd_data !== 8'h00) begin
      n_err++;
      $display("FAIL fill_ignore: lvl=%0d data=%02h want %0d/00", level, rd_data, DEPTH);
    end
    drain();
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    n_cmp++;
    if (full !== 1'b0 || rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fill_drained: f=%b v=%b want 0/0", full, rd_valid);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] d;
    d = W'($urandom_range(0, 200));
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, d, 1'b0, 1'b0);
      d = d + 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, d, 1'b1, 1'b0);
      d = d + 1'b1;
      n_cmp++;
      if (level !== LW'(3)) begin
        n_err++;
        $display("FAIL wrap_level: got %0d want 3 at step %0d", level, i);
      end
    end
    drain();
  endtask

  task automatic test_simul();
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, W'(8'hC0 + i), 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h55, 1'b1, 1'b0);
    n_cmp++;
    if (level !== LW'(DEPTH - 1) || full !== 1'b0) begin
      n_err++;
      $display("FAIL full_simul: lvl=%0d f=%b want %0d/0", level, full, DEPTH - 1);
    end
    drain();
    drive_cycle(1'b1, 8'h66, 1'b1, 1'b0);
    n_cmp++;
    if (level !== LW'(1) || rd_data !== 8'h66 || rd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL empty_simul: lvl=%0d data=%02h v=%b want 1/66/1", level, rd_data, rd_valid);
    end
    drain();
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, W'($urandom_range(0, 255)), 1'b0, 1'b0);
    wr_en = 1'b1; wr_data = 8'hEE; rd_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    n_cmp++;
    if (level !== '0 || rd_valid !== 1'b0 || full !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: lvl=%0d v=%b f=%b o=%b want 0/0/0/0", level, rd_valid, full, ovf);
    end
    wr_en = 1'b0; rd_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    drive_cycle(1'b1, 8'h77, 1'b0, 1'b0);
    n_cmp++;
    if (rd_data !== 8'h77 || level !== LW'(1)) begin
      n_err++;
      $display("FAIL reset_recover: data=%02h lvl=%0d want 77/1", rd_data, level);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_simul();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d queued words want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
